// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: FSM encoding, opcode width and MISR constants shared by the ALU BIST slice.
package alu_bist_pkg;
   localparam int OP_W = 4;
   localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;
   localparam logic [31:0] MISR_TAPS = 32'h8020_0003;
   typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;
   function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] r,
                                             input logic [31:0] r2);
      return {sig[30:0], ^(sig & MISR_TAPS)} ^ r ^ {r2[15:0], r2[31:16]};
   endfunction
endpackage

// File: rtl/alu_bist_misr.sv
// alu_bist_misr: 32-bit MISR folding ALU Result and half-swapped Result2 into a signature.
module alu_bist_misr
   import alu_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        en_i,
   input  logic [31:0] data_i,
   input  logic [31:0] data2_i,
   output logic [31:0] sig_o
);
   logic [31:0] sig_q, sig_d;
   always_comb sig_d = load_i ? MISR_SEED : en_i ? misr_step(sig_q, data_i, data2_i) : sig_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end
   assign sig_o = sig_q;
endmodule

// File: rtl/alu_bist.sv
// alu_bist: sweeps ALU opcodes over a latched operand pair, compressing results and collecting flags.
module alu_bist
   import alu_bist_pkg::*;
#(
   parameter int unsigned NUM_OPS = 16,
   parameter int unsigned SETTLE  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [31:0]     op_x,
   input  logic [31:0]     op_y,
   output logic [OP_W-1:0] alu_s,
   output logic [31:0]     alu_x,
   output logic [31:0]     alu_y,
   input  logic [31:0]     alu_result,
   input  logic [31:0]     alu_result2,
   input  logic            alu_equal,
   input  logic            alu_overflow,
   input  logic            alu_uof,
   output logic            busy,
   output logic            done,
   output logic [31:0]     signature,
   output logic [15:0]     eq_vec,
   output logic [15:0]     ovf_vec,
   output logic [15:0]     uof_vec
);
   localparam logic [OP_W-1:0] LAST_OP  = OP_W'(NUM_OPS - 1);
   localparam logic [3:0]      LAST_SET = 4'(SETTLE - 1);
   state_t          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [3:0]      set_q, set_d;
   logic [31:0]     x_q, x_d, y_q, y_d;
   logic [15:0]     eq_q, eq_d, ovf_q, ovf_d, uof_q, uof_d;
   logic            accept, cap;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      set_d   = set_q;
      x_d     = x_q;
      y_d     = y_q;
      eq_d    = eq_q;
      ovf_d   = ovf_q;
      uof_d   = uof_q;
      accept  = (state_q == IDLE) && start;
      cap     = (state_q == CAPTURE);
      case (state_q)
         IDLE: if (start) begin
            state_d = DRIVE;
            op_d    = '0;
            set_d   = '0;
            x_d     = op_x;
            y_d     = op_y;
            eq_d    = '0;
            ovf_d   = '0;
            uof_d   = '0;
         end
         DRIVE: begin
            set_d   = (set_q == LAST_SET) ? 4'd0 : set_q + 4'd1;
            state_d = (set_q == LAST_SET) ? CAPTURE : DRIVE;
         end
         CAPTURE: begin
            eq_d[op_q]  = alu_equal;
            ovf_d[op_q] = alu_overflow;
            uof_d[op_q] = alu_uof;
            // the counter parks on the last opcode so alu_s keeps showing it afterwards
            state_d     = (op_q == LAST_OP) ? DONE : DRIVE;
            op_d        = (op_q == LAST_OP) ? op_q : op_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         set_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         eq_q    <= '0;
         ovf_q   <= '0;
         uof_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         set_q   <= set_d;
         x_q     <= x_d;
         y_q     <= y_d;
         eq_q    <= eq_d;
         ovf_q   <= ovf_d;
         uof_q   <= uof_d;
      end
   end
   alu_bist_misr u_misr (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .en_i   (cap),
      .data_i (alu_result),
      .data2_i(alu_result2),
      .sig_o  (signature)
   );
   assign alu_s   = op_q;
   assign alu_x   = x_q;
   assign alu_y   = y_q;
   assign busy    = state_q != IDLE;
   assign done    = state_q == DONE;
   assign eq_vec  = eq_q;
   assign ovf_vec = ovf_q;
   assign uof_vec = uof_q;
endmodule
